// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RISC-V execute stage: forwarding, ALU, branch resolve, EX/MEM register
// Combinational branch redirect leaves this stage; everything else is registered into EX/MEM.
module execute_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              valid_e,
  input  logic              reg_write_e,
  input  logic              mem_write_e,
  input  logic              result_src_e,
  input  logic              branch_e,
  input  logic              alu_src_e,
  input  logic [2:0]        alu_control_e,
  input  logic [XLEN-1:0]   rd1_e,
  input  logic [XLEN-1:0]   rd2_e,
  input  logic [XLEN-1:0]   imm_ext_e,
  input  logic [XLEN-1:0]   pc_e,
  input  logic [XLEN-1:0]   pc_plus4_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [1:0]        forward_a_e,
  input  logic [1:0]        forward_b_e,
  input  logic [XLEN-1:0]   result_w,
  output logic              pc_src_e,
  output logic [XLEN-1:0]   pc_target_e,
  output logic              valid_m,
  output logic              reg_write_m,
  output logic              mem_write_m,
  output logic              result_src_m,
  output logic [REG_AW-1:0] rd_m,
  output logic [XLEN-1:0]   alu_result_m,
  output logic [XLEN-1:0]   write_data_m,
  output logic [XLEN-1:0]   pc_plus4_m
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [XLEN-1:0]   src_a, fwd_b, src_b, alu_result;
  logic              zero;

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_write_q, mem_write_d;
  logic              result_src_q, result_src_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   alu_result_q, alu_result_d;
  logic [XLEN-1:0]   write_data_q, write_data_d;
  logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;

  // Forwarding from MEM reads the register's current (pre-edge) value.
  always_comb begin
    src_a = rd1_e;
    case (forward_a_e)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_q;
      default: src_a = rd1_e;
    endcase
    fwd_b = rd2_e;
    case (forward_b_e)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = rd2_e;
    endcase
    src_b = alu_src_e ? imm_ext_e : fwd_b;
  end

  always_comb begin
    alu_result = '0;
    case (alu_control_e)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero        = (alu_result == '0);
  assign pc_target_e = pc_e + imm_ext_e;
  assign pc_src_e    = valid_e & branch_e & zero;

  // Flush beats stall; reset is applied in the register process itself.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    if (flush_e) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 1'b0;
      rd_d         = '0;
      alu_result_d = '0;
      write_data_d = '0;
      pc_plus4_d   = '0;
    end else if (!stall_e) begin
      valid_d      = valid_e;
      reg_write_d  = reg_write_e & valid_e;
      mem_write_d  = mem_write_e & valid_e;
      result_src_d = result_src_e;
      rd_d         = rd_e;
      alu_result_d = alu_result;
      write_data_d = fwd_b;
      pc_plus4_d   = pc_plus4_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign valid_m      = valid_q;
  assign reg_write_m  = reg_write_q;
  assign mem_write_m  = mem_write_q;
  assign result_src_m = result_src_q;
  assign rd_m         = rd_q;
  assign alu_result_m = alu_result_q;
  assign write_data_m = write_data_q;
  assign pc_plus4_m   = pc_plus4_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage
// Directed vector table, hand sequences for stall/flush/reset, then randomized traffic vs. a model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stall_e, flush_e, valid_e, reg_write_e, mem_write_e, result_src_e;
  logic        branch_e, alu_src_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w;
  logic [4:0]  rd_e;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        pc_src_e, valid_m, reg_write_m, mem_write_m, result_src_m;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]  rd_m;

  int tests = 0;
  int fails = 0;

  // Model of the EX/MEM register contents
  logic        m_valid, m_rw, m_mw, m_rs;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_pc4;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_e(valid_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .result_src_e(result_src_e),
    .branch_e(branch_e), .alu_src_e(alu_src_e), .alu_control_e(alu_control_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .rd_e(rd_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .result_w(result_w),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .valid_m(valid_m),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
    .rd_m(rd_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .pc_plus4_m(pc_plus4_m)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [1:0]  fa, fb;
    logic [31:0] res_w;
    logic        asrc;
    logic [31:0] imm;
    logic        br;
    logic [31:0] pc;
    logic [31:0] e_alu;
    logic        e_src;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r);
    if (sel == 2'd1) return result_w;
    if (sel == 2'd2) return m_alu;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic tick();
    logic [31:0] a, fb, r;
    a  = pick(forward_a_e, rd1_e);
    fb = pick(forward_b_e, rd2_e);
    r  = alu_ref(alu_control_e, a, alu_src_e ? imm_ext_e : fb);
    #1;
    check("pc_src_e", {31'd0, pc_src_e}, {31'd0, valid_e & branch_e & (r == 32'd0)});
    check("pc_target_e", pc_target_e, pc_e + imm_ext_e);
    @(posedge clk);
    if (rst || flush_e) begin
      {m_valid, m_rw, m_mw, m_rs} = 4'b0;
      m_rd = '0; m_alu = '0; m_wd = '0; m_pc4 = '0;
    end else if (!stall_e) begin
      m_valid = valid_e;
      m_rw    = reg_write_e & valid_e;
      m_mw    = mem_write_e & valid_e;
      m_rs    = result_src_e;
      m_rd    = rd_e;
      m_alu   = r;
      m_wd    = fb;
      m_pc4   = pc_plus4_e;
    end
    #1;
    check("valid_m", {31'd0, valid_m}, {31'd0, m_valid});
    check("reg_write_m", {31'd0, reg_write_m}, {31'd0, m_rw});
    check("mem_write_m", {31'd0, mem_write_m}, {31'd0, m_mw});
    check("result_src_m", {31'd0, result_src_m}, {31'd0, m_rs});
    check("rd_m", {27'd0, rd_m}, {27'd0, m_rd});
    check("alu_result_m", alu_result_m, m_alu);
    check("write_data_m", write_data_m, m_wd);
    check("pc_plus4_m", pc_plus4_m, m_pc4);
  endtask

  task automatic rand_inputs();
    valid_e       = 1'($urandom);
    reg_write_e   = 1'($urandom);
    mem_write_e   = 1'($urandom);
    result_src_e  = 1'($urandom);
    branch_e      = 1'($urandom);
    alu_src_e     = 1'($urandom);
    alu_control_e = 3'($urandom);
    rd1_e         = ($urandom_range(0, 3) == 0) ? rd2_e : $urandom;
    rd2_e         = $urandom;
    imm_ext_e     = $urandom;
    pc_e          = $urandom;
    pc_plus4_e    = pc_e + 32'd4;
    rd_e          = 5'($urandom);
    forward_a_e   = 2'($urandom_range(0, 3));
    forward_b_e   = 2'($urandom_range(0, 3));
    result_w      = $urandom;
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rw,
                              input logic asrc, input logic [31:0] imm, input logic br,
                              input logic [31:0] pc, input logic [31:0] ea, input logic es,
                              input logic [31:0] et);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.fa = fa; v.fb = fb; v.res_w = rw; v.asrc = asrc;
    v.imm = imm; v.br = br; v.pc = pc; v.e_alu = ea; v.e_src = es; v.e_tgt = et;
    return v;
  endfunction

  initial begin
    {stall_e, flush_e} = 2'b00;
    rd2_e = 32'd0;
    rand_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    {m_valid, m_rw, m_mw, m_rs} = 4'b0;
    m_rd = '0; m_alu = '0; m_wd = '0; m_pc4 = '0;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      tick();
    end
    check("reset alu_result_m", alu_result_m, 32'd0);
    check("reset valid_m", {31'd0, valid_m}, 32'd0);
    rst = 1'b0;

    tbl.push_back(mk(3'd0, 32'd7, 32'd5, 2'd0, 2'd0, 0, 0, 32'd0, 0, 32'd0, 32'd12, 0, 32'd0));
    tbl.push_back(mk(3'd1, 32'd7, 32'd5, 2'd0, 2'd0, 0, 0, 32'd0, 0, 32'd0, 32'd2, 0, 32'd0));
    tbl.push_back(mk(3'd1, 32'd0, 32'd1, 2'd0, 2'd0, 0, 0, 32'd0, 0, 32'd0, 32'hFFFF_FFFF, 0, 32'd0));
    tbl.push_back(mk(3'd5, 32'h8000_0000, 32'd1, 2'd0, 2'd0, 0, 0, 32'd0, 0, 32'd0, 32'd1, 0, 32'd0));
    tbl.push_back(mk(3'd5, 32'd1, 32'h8000_0000, 2'd0, 2'd0, 0, 0, 32'd0, 0, 32'd0, 32'd0, 0, 32'd0));
    tbl.push_back(mk(3'd0, 32'h10, 32'd0, 2'd0, 2'd0, 0, 0, 32'd0, 0, 32'd0, 32'h10, 0, 32'd0));
    tbl.push_back(mk(3'd1, 32'd0, 32'd0, 2'd2, 2'd1, 32'h10, 0, 32'hFFFF_FFF8, 1, 32'h100,
                     32'd0, 1, 32'hF8));
    tbl.push_back(mk(3'd1, 32'd5, 32'd3, 2'd0, 2'd0, 0, 0, 32'd16, 1, 32'h40, 32'd2, 0, 32'h50));
    tbl.push_back(mk(3'd2, 32'hF0F0, 32'hFF00, 2'd0, 2'd0, 0, 0, 32'd0, 0, 32'd0, 32'hF000, 0, 32'd0));
    tbl.push_back(mk(3'd3, 32'hF0F0, 32'hFF00, 2'd0, 2'd0, 0, 0, 32'd0, 0, 32'd0, 32'hFFF0, 0, 32'd0));
    tbl.push_back(mk(3'd4, 32'd5, 32'd3, 2'd0, 2'd0, 0, 0, 32'd0, 0, 32'd0, 32'd0, 0, 32'd0));
    tbl.push_back(mk(3'd7, 32'd5, 32'd3, 2'd0, 2'd0, 0, 0, 32'd0, 0, 32'd0, 32'd0, 0, 32'd0));
    tbl.push_back(mk(3'd0, 32'd3, 32'd9, 2'd0, 2'd0, 0, 1, 32'hFFFF_FFFF, 0, 32'd0, 32'd2, 0,
                     32'hFFFF_FFFF));

    for (int i = 0; i < tbl.size(); i++) begin
      valid_e = 1'b1; reg_write_e = 1'b1; mem_write_e = 1'b0; result_src_e = 1'b0;
      alu_control_e = tbl[i].op; rd1_e = tbl[i].a; rd2_e = tbl[i].b;
      forward_a_e = tbl[i].fa; forward_b_e = tbl[i].fb; result_w = tbl[i].res_w;
      alu_src_e = tbl[i].asrc; imm_ext_e = tbl[i].imm; branch_e = tbl[i].br;
      pc_e = tbl[i].pc; pc_plus4_e = tbl[i].pc + 32'd4; rd_e = 5'(i + 1);
      #1;
      check($sformatf("vec%0d pc_src", i), {31'd0, pc_src_e}, {31'd0, tbl[i].e_src});
      check($sformatf("vec%0d target", i), pc_target_e, tbl[i].e_tgt);
      tick();
      check($sformatf("vec%0d alu", i), alu_result_m, tbl[i].e_alu);
    end

    // Stall three cycles with changing inputs, then stall+flush gives a bubble.
    begin
      logic [31:0] held;
      held = alu_result_m;
      stall_e = 1'b1;
      for (int i = 0; i < 3; i++) begin
        rand_inputs();
        tick();
      end
      check("stall hold alu", alu_result_m, held);
      flush_e = 1'b1;
      tick();
      check("flush alu", alu_result_m, 32'd0);
      check("flush valid", {31'd0, valid_m}, 32'd0);
      {stall_e, flush_e} = 2'b00;
    end

    // Invalid instruction suppresses write enables and the redirect.
    valid_e = 1'b0; reg_write_e = 1'b1; mem_write_e = 1'b1; branch_e = 1'b1;
    alu_control_e = 3'd1; rd1_e = 32'd5; rd2_e = 32'd5; alu_src_e = 1'b0;
    forward_a_e = 2'd0; forward_b_e = 2'd0;
    #1;
    check("invalid pc_src", {31'd0, pc_src_e}, 32'd0);
    tick();
    check("invalid reg_write_m", {31'd0, reg_write_m}, 32'd0);
    check("invalid mem_write_m", {31'd0, mem_write_m}, 32'd0);

    // Reset during a stall still clears.
    valid_e = 1'b1; alu_control_e = 3'd0; rd1_e = 32'd9;
    tick();
    stall_e = 1'b1; rst = 1'b1;
    tick();
    check("rst in stall alu", alu_result_m, 32'd0);
    {stall_e, rst} = 2'b00;

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst     = ($urandom_range(0, 31) == 0);
      flush_e = ($urandom_range(0, 7) == 0);
      stall_e = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
